// File: rtl/approx_adder_pkg.sv
// Shared defaults, scheduler state encoding and a constant clog2 helper
// for the approximate-adder round-robin scheduler.
package approx_adder_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int APPROX_BITS_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_or_adder_core.sv
// Combinational adder: ripple full-adder chain, with the low APPROX_BITS
// replaced by a carry-free OR when approx is set.
module approx_or_adder_core
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  // carry-in is ignored in approximate mode
  assign c[0] = cin & ~approx;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic fa_s;
    logic fa_co;
    assign fa_s  = a[i] ^ b[i] ^ c[i];
    assign fa_co = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));

    if (i < APPROX_BITS) begin : g_lsb
      assign sum[i] = approx ? (a[i] | b[i]) : fa_s;
      // top OR bit feeds its AND into the exact upper part as c_k
      if (i == APPROX_BITS - 1) begin : g_ck
        assign c[i+1] = approx ? (a[i] & b[i]) : fa_co;
      end else begin : g_cz
        assign c[i+1] = approx ? 1'b0 : fa_co;
      end
    end else begin : g_msb
      assign sum[i] = fa_s;
      assign c[i+1] = fa_co;
    end
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/approx_adder_rr_scheduler.sv
// Round-robin arbiter sharing one approximate adder among N_REQ requesters,
// with a single-entry registered valid/ready response stage.
module approx_adder_rr_scheduler
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int N_REQ       = 4,
  parameter int ID_W        = clog2(N_REQ),
  parameter int APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  input  logic [N_REQ-1:0]       req_approx,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic [ID_W-1:0]        rsp_id
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic             accept_en;
  logic             xfer;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout;

  // Descending scan so the smallest offset from rr_ptr wins without a break.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req_valid[(int'(rr_ptr_q) + off) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
      end
    end
  end

  assign accept_en = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & rsp_ready));
  assign xfer      = accept_en & grant_vld;
  assign req_ready = xfer ? (N_REQ'(1) << grant_idx) : '0;

  approx_or_adder_core #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(APPROX_BITS)
  ) u_core (
    .a     (req_a[grant_idx*WIDTH +: WIDTH]),
    .b     (req_b[grant_idx*WIDTH +: WIDTH]),
    .cin   (req_cin[grant_idx]),
    .approx(req_approx[grant_idx]),
    .sum   (core_sum),
    .cout  (core_cout)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    if (xfer) begin
      state_d    = HOLD;
      rr_ptr_d   = ID_W'((int'(grant_idx) + 1) % N_REQ);
      rsp_id_d   = grant_idx;
      rsp_sum_d  = core_sum;
      rsp_cout_d = core_cout;
    end else if ((state_q == HOLD) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_approx_adder_rr_scheduler.sv
// Scoreboard bench: a negedge reference model predicts grants and results,
// a monitor compares the response channel against the expected queue.
module tb_approx_adder_rr_scheduler;

  localparam int W = 8;
  localparam int N = 4;
  localparam int K = 1;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   id;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_approx;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  int   m_ptr = 0;

  approx_adder_rr_scheduler #(
    .WIDTH(W), .N_REQ(N), .ID_W(2), .APPROX_BITS(K)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_approx(req_approx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic written from the mode rules with plain integers.
  function automatic logic [W:0] ref_add(input int a, input int b, input int cin, input int apx);
    int lo, hi;
    if (apx == 0) return (W+1)'(a + b + cin);
    lo = (a | b) & ((1 << K) - 1);
    hi = (a >> K) + (b >> K) + (((a >> (K - 1)) & (b >> (K - 1))) & 1);
    return (W+1)'((hi << K) | lo);
  endfunction

  // Monitor first retires the current response, then the model predicts this cycle's grant.
  always @(negedge clk) begin
    int   g;
    rsp_t e;
    logic [W:0] r;
    if (!rst_n) begin
      check("ready_in_reset", 32'(req_ready), 32'd0);
      exp_q.delete();
      m_ptr = 0;
    end else begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
      if (rsp_valid && exp_q.size() != 0) begin
        check("rsp_sum", 32'(rsp_sum), 32'(exp_q[0].sum));
        check("rsp_cout", 32'(rsp_cout), 32'(exp_q[0].cout));
        check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        if (rsp_ready) void'(exp_q.pop_front());
      end
      g = -1;
      if (exp_q.size() == 0) begin
        for (int off = 0; off < N; off++) begin
          if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        end
      end
      check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (g >= 0) begin
        r = ref_add(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]),
                    int'(req_cin[g]), int'(req_approx[g]));
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.id   = 2'(g);
        exp_q.push_back(e);
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic apx);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_approx[i]   = apx;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    rsp_ready  = 1'b1;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    req_approx = '0;

    // reset with all requesters asserting valid
    cyc();
    cyc();
    check("t1_ready", 32'(req_ready), 32'd0);
    check("t1_valid", 32'(rsp_valid), 32'd0);
    check("t1_sum", 32'(rsp_sum), 32'd0);
    check("t1_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    cyc();

    // exact vs approximate
    set_req(0, 8'h0F, 8'h01, 1'b0, 1'b0);
    req_valid = 4'b0001;
    cyc();
    check("t2_exact_sum", 32'(rsp_sum), 32'h10);
    check("t2_exact_cout", 32'(rsp_cout), 32'd0);
    set_req(0, 8'h0F, 8'h01, 1'b0, 1'b1);
    cyc();
    check("t2_approx_sum", 32'(rsp_sum), 32'h11);
    set_req(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    cyc();
    check("t2_wrap_sum", 32'(rsp_sum), 32'h00);
    check("t2_wrap_cout", 32'(rsp_cout), 32'd1);
    req_valid = '0;
    cyc();

    // round robin with all requesters valid
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 17), 8'(i + 3), 1'b1, 1'b0);
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      cyc();
      check("t3_rr_id", 32'(rsp_id), 32'(n % N));
    end
    req_valid = '0;
    cyc();

    // backpressure, then same-cycle retire and accept
    do_reset();
    set_req(0, 8'h0F, 8'h01, 1'b0, 1'b1);
    set_req(2, 8'h20, 8'h22, 1'b1, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 4'b0100;
    for (int n = 0; n < 5; n++) begin
      check("t4_hold_ready", 32'(req_ready), 32'd0);
      check("t4_hold_sum", 32'(rsp_sum), 32'h11);
      check("t4_hold_id", 32'(rsp_id), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    check("t4_next_id", 32'(rsp_id), 32'd2);
    check("t4_next_sum", 32'(rsp_sum), 32'h43);
    req_valid = '0;
    cyc();

    // sparse traffic
    do_reset();
    req_valid = 4'b0010;
    cyc();
    check("t5_id1", 32'(rsp_id), 32'd1);
    req_valid = 4'b1000;
    cyc();
    check("t5_id3", 32'(rsp_id), 32'd3);
    req_valid = 4'b1001;
    cyc();
    check("t5_id0", 32'(rsp_id), 32'd0);
    req_valid = '0;
    cyc();

    // reset while holding a result
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cyc();
    rst_n     = 1'b0;
    req_valid = '0;
    cyc();
    check("t6_valid", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    cyc();
    check("t6_id", 32'(rsp_id), 32'd1);
    req_valid = '0;
    cyc();

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      req_valid  = 4'($urandom);
      req_a      = 32'($urandom);
      req_b      = 32'($urandom);
      req_cin    = 4'($urandom);
      req_approx = 4'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      cyc();
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) cyc();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
